// File: rtl/bar_peak_feeder.sv
// bar_peak_feeder: windowed max, peak-hold and linear decay feeding an LED bar driver
module bar_peak_feeder #(
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HOLD_TICKS  = 8,
  parameter int DECAY_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] level_o,
  output logic              level_update_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_TICKS);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(DECAY_STEP);
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] win, m, peak, peak_nx, dec, r, level_d;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic tick, upd_d;
  assign tick = cnt == CNT_MAX;
  assign m = sample_valid_i && sample_i > win ? sample_i : win;
  assign dec = peak > STEP ? peak - STEP : '0;
  assign r = dec > m ? dec : m;
  // state register; only advances on a refresh tick, clear forces IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (clr_i) state <= IDLE;
    else if (tick) state <= state_nx;
  end
  // next peak/hold/state as they would be committed at this tick
  always_comb begin
    state_nx = state;
    peak_nx = peak;
    hold_nx = hold_cnt;
    if (m > peak || (m == peak && peak != '0)) begin
      peak_nx = m;
      hold_nx = HOLD_LD;
      state_nx = HOLD_TICKS == 0 ? DECAY : HOLD;
    end else if (state == HOLD) begin
      hold_nx = hold_cnt - HW'(1);
      state_nx = hold_cnt <= HW'(1) ? DECAY : HOLD;
    end else if (state == DECAY) begin
      peak_nx = r;
      if (r == '0) state_nx = IDLE;
      else if (r == m) begin
        hold_nx = HOLD_LD;
        state_nx = HOLD_TICKS == 0 ? DECAY : HOLD;
      end
    end
  end
  // output values to present next cycle: clear publishes a zero level
  always_comb begin
    level_d = clr_i ? '0 : peak_nx;
    upd_d = clr_i | tick;
  end
  // refresh counter, window max, peak tracking and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      win <= '0;
      peak <= '0;
      hold_cnt <= '0;
      level_o <= '0;
      level_update_o <= 1'b0;
    end else begin
      cnt <= clr_i || tick ? '0 : cnt + CW'(1);
      win <= clr_i || tick ? '0 : m;
      peak <= clr_i ? '0 : tick ? peak_nx : peak;
      hold_cnt <= clr_i ? '0 : tick ? hold_nx : hold_cnt;
      level_o <= upd_d ? level_d : level_o;
      level_update_o <= upd_d;
    end
  end
endmodule

// File: tb/tb_bar_peak_feeder.sv
// tb_bar_peak_feeder: scoreboard bench for the peak-hold/decay level feeder
module tb_bar_peak_feeder;
  logic clk = 0, rst = 1, clr = 0, v = 0;
  logic [3:0] s = 0;
  logic [3:0] lvl, lvl0;
  logic upd, upd0;
  typedef struct {logic [3:0] l; int g;} exp_t;
  exp_t q[$], q0[$];
  int tests = 0, fails = 0, pe = 0, last = 0, last0 = 0;
  bit chk0 = 0;

  bar_peak_feeder #(.DATA_W(4), .REFRESH_DIV(4), .HOLD_TICKS(2), .DECAY_STEP(3)) dut (
    .clk(clk), .rst(rst), .sample_i(s), .sample_valid_i(v), .clr_i(clr),
    .level_o(lvl), .level_update_o(upd));

  bar_peak_feeder #(.DATA_W(4), .REFRESH_DIV(4), .HOLD_TICKS(0), .DECAY_STEP(3)) dut0 (
    .clk(clk), .rst(rst), .sample_i(s), .sample_valid_i(v), .clr_i(clr),
    .level_o(lvl0), .level_update_o(upd0));

  always #5 clk = ~clk;

  // clock edges seen out of reset, used to measure spacing between pulses
  always @(posedge clk) if (!rst) pe <= pe + 1;

  task automatic check(input string n, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, req, $time);
    end
  endtask

  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = pe;
        last0 = pe;
      end else begin
        if (upd) begin
          if (q.size() == 0) check("main unexpected pulse", 1, 0);
          else begin
            e = q.pop_front();
            check("main level", lvl, e.l);
            check("main gap", pe - last, e.g);
          end
          last = pe;
        end
        if (upd0) begin
          if (chk0) begin
            if (q0.size() == 0) check("hold0 unexpected pulse", 1, 0);
            else begin
              e = q0.pop_front();
              check("hold0 level", lvl0, e.l);
              check("hold0 gap", pe - last0, e.g);
            end
          end
          last0 = pe;
        end
      end
    end
  endtask

  task automatic cyc(input logic [3:0] sv, input logic vv, input logic cv);
    s = sv;
    v = vv;
    clr = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [3:0] l, input logic [3:0] l0, input int g);
    q.push_back('{l, g});
    if (chk0) q0.push_back('{l0, g});
  endtask

  task automatic win(input logic [3:0] l, input logic [3:0] l0, input logic [3:0] sv, input int at);
    ex(l, l0, 4);
    for (int i = 0; i < 4; i++) cyc(sv, i == at, 1'b0);
  endtask

  // n windows: the first carries smp at step 'at', the rest are empty; levels read MSB nibble first
  task automatic run(input logic [3:0] smp, input int at, input int n, input logic [63:0] e, input logic [63:0] e0);
    for (int k = 0; k < n; k++) win(e[63-4*k -: 4], e0[63-4*k -: 4], smp, k == 0 ? at : -1);
  endtask

  initial begin
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    check("reset level", lvl, 0);
    check("reset strobe", upd, 0);
    check("reset level hold0", lvl0, 0);
    rst = 0;
    // single peak: hold three ticks, then decay by 3 to zero
    run(4'd12, 0, 8, 64'hCCC96300_00000000, 64'h0);
    // window max rather than last sample
    ex(4'd14, 4'd0, 4);
    cyc(4'd5, 1'b1, 1'b0);
    cyc(4'd14, 1'b1, 1'b0);
    cyc(4'd7, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0);
    run(4'd0, -1, 7, 64'hEEB85200_00000000, 64'h0);
    // higher sample during decay re-holds; a low sample clamps decay and re-holds
    run(4'd12, 0, 4, 64'hCCC90000_00000000, 64'h0);
    run(4'd11, 0, 7, 64'hBBB85200_00000000, 64'h0);
    run(4'd12, 0, 4, 64'hCCC90000_00000000, 64'h0);
    win(4'd6, 4'd0, 4'd4, 0);
    win(4'd4, 4'd0, 4'd4, 0);
    run(4'd0, -1, 4, 64'h44100000_00000000, 64'h0);
    // sample in the tick cycle closes into that window; next window starts empty
    run(4'd13, 3, 8, 64'hDDDA7410_00000000, 64'h0);
    // clear in tick cycle: one zero pulse, counter restarts
    win(4'd12, 4'd0, 4'd12, 0);
    ex(4'd0, 4'd0, 4);
    cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b1);
    win(4'd0, 4'd0, 4'd0, -1);
    // held clear: a pulse every cycle
    win(4'd12, 4'd0, 4'd12, 0);
    for (int i = 0; i < 3; i++) ex(4'd0, 4'd0, 1);
    for (int i = 0; i < 3; i++) cyc(4'd0, 1'b0, 1'b1);
    win(4'd0, 4'd0, 4'd0, -1);
    // clear mid-window discards the partial window max
    win(4'd12, 4'd0, 4'd12, 0);
    ex(4'd0, 4'd0, 2);
    cyc(4'd12, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b1);
    win(4'd0, 4'd0, 4'd0, -1);
    // asynchronous reset mid-window while showing 12
    win(4'd12, 4'd0, 4'd12, 0);
    cyc(4'd0, 1'b0, 1'b0);
    rst = 1;
    chk0 = 1;
    #1;
    check("async reset level", lvl, 0);
    check("async reset strobe", upd, 0);
    @(posedge clk);
    #1;
    rst = 0;
    // both hold settings side by side; zero hold decays on the very next tick
    run(4'd12, 0, 8, 64'hCCC96300_00000000, 64'hC9630000_00000000);
    repeat (2) @(posedge clk);
    #1;
    check("main queue drained", q.size(), 0);
    check("hold0 queue drained", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
